// File: rtl/blit_cmd_arbiter_pkg.sv
// Shared types and widths for the blitter command arbiter.
package blit_cmd_arbiter_pkg;

  localparam int BLIT_CMD_W = 96;
  localparam int GRANT_W    = 3;

  typedef logic [BLIT_CMD_W-1:0] blit_cmd_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/blit_cmd_arbiter_if.sv
// Requester-side and blitter-FIFO-side handshake bundle of the command arbiter.
interface blit_cmd_arbiter_if
  import blit_cmd_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*BLIT_CMD_W-1:0] req_cmd;
  logic [NREQ-1:0]            req_ready;
  blit_cmd_t                  blit_cmd;
  logic                       blit_cmd_valid;

  // Arbiter view: consumes requests, drives the blitter FIFO write port.
  modport slave (
    input  req_valid,
    input  req_cmd,
    output req_ready,
    output blit_cmd,
    output blit_cmd_valid
  );

  // Environment view: requesters plus the blitter FIFO.
  modport master (
    output req_valid,
    output req_cmd,
    input  req_ready,
    input  blit_cmd,
    input  blit_cmd_valid
  );

endinterface

// File: rtl/blit_cmd_arbiter_chk.sv
// Protocol checker for the blitter command arbiter outputs.
module blit_cmd_arbiter_chk #(
  parameter int NREQ = 2
) (
  input logic            clock,
  input logic            reset_n,
  input logic [NREQ-1:0] req_valid,
  input logic [NREQ-1:0] req_ready,
  input logic            blit_cmd_valid
);

  a_no_back_to_back_strobe : assert property (
    @(posedge clock) disable iff (!reset_n) blit_cmd_valid |=> !blit_cmd_valid
  ) else $error("blit_cmd_valid high two cycles in a row");

  a_ready_onehot0 : assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(req_ready)
  ) else $error("req_ready not onehot0");

  for (genvar i = 0; i < NREQ; i++) begin : g_ready_has_valid
    a_ready_after_valid : assert property (
      @(posedge clock) disable iff (!reset_n) req_ready[i] |-> $past(req_valid[i])
    ) else $error("req_ready without prior req_valid");
  end

endmodule

// File: rtl/blit_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request after the last grant.
module blit_cmd_arbiter_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      last_i,
  output logic            found_o,
  output logic [2:0]      idx_o
);

  logic [7:0] req_pad_s;

  // Scan from the farthest candidate back to last+1 so the nearest valid requester wins.
  always_comb begin
    req_pad_s            = 8'd0;
    req_pad_s[NREQ-1:0]  = req_i;
    found_o              = 1'b0;
    idx_o                = 3'd0;
    for (int k = NREQ; k >= 1; k--) begin
      logic [2:0] pos;
      pos     = 3'((int'(last_i) + k) % NREQ);
      found_o = found_o | req_pad_s[pos];
      idx_o   = req_pad_s[pos] ? pos : idx_o;
    end
  end

endmodule

// File: rtl/blit_cmd_arbiter.sv
// Round-robin arbiter sharing the blitter command port; one command per grant,
// gated by FIFO space, with a hold-off after each issue.
module blit_cmd_arbiter
  import blit_cmd_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MIN_FREE = 1,
  parameter int HOLDOFF  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic [7:0]          blit_fifo_slots_free_i,
  blit_cmd_arbiter_if.slave   bus,
  output logic [GRANT_W-1:0]  grant_id_o,
  output logic                busy_o,
  output logic [31:0]         issued_count_o
);

  arb_state_e         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  blit_cmd_t          cmd_q, cmd_d;
  logic               valid_q, valid_d;
  logic [NREQ-1:0]    ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [31:0]        issued_count_q, issued_count_d;

  logic               found_s;
  logic [GRANT_W-1:0] pick_s;
  logic               slots_ok_s;

  blit_cmd_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i   (bus.req_valid),
    .last_i  (grant_q),
    .found_o (found_s),
    .idx_o   (pick_s)
  );

  assign slots_ok_s = (32'(blit_fifo_slots_free_i) >= 32'(MIN_FREE));

  // Next-state logic: grant in IDLE, count down the hold-off window in HOLD.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    cmd_d          = cmd_q;
    valid_d        = 1'b0;
    ready_d        = '0;
    issued_count_d = issued_count_q;
    case (state_q)
      IDLE: begin
        if (enable_i && found_s && slots_ok_s) begin
          for (int i = 0; i < NREQ; i++) begin
            ready_d[i] = (pick_s == 3'(i));
            if (pick_s == 3'(i)) begin
              cmd_d = bus.req_cmd[i*BLIT_CMD_W +: BLIT_CMD_W];
            end else begin
              cmd_d = cmd_d;
            end
          end
          valid_d        = 1'b1;
          grant_d        = pick_s;
          issued_count_d = issued_count_q + 32'd1;
          cnt_d          = 8'(HOLDOFF);
          state_d        = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d == HOLD);
  end

  // State and output registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      grant_q        <= 3'(NREQ - 1);
      cmd_q          <= '0;
      valid_q        <= 1'b0;
      ready_q        <= '0;
      busy_q         <= 1'b0;
      issued_count_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      cmd_q          <= cmd_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign bus.blit_cmd       = cmd_q;
  assign bus.blit_cmd_valid = valid_q;
  assign bus.req_ready      = ready_q;
  assign grant_id_o         = grant_q;
  assign busy_o             = busy_q;
  assign issued_count_o     = issued_count_q;

endmodule

// File: tb/tb_blit_cmd_arbiter.sv
// Directed bench for blit_cmd_arbiter (NREQ=2, MIN_FREE=1, HOLDOFF=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_blit_cmd_arbiter;
  import blit_cmd_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam blit_cmd_t CMD_A = 96'hA;
  localparam blit_cmd_t CMD0  = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam blit_cmd_t CMD1  = 96'hFEDC_BA98_7654_3210_4455_6677;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  slots;
  logic [2:0]  grant_id;
  logic        busy;
  logic [31:0] issued_count;

  int vectors    = 0;
  int miscompares = 0;

  blit_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

  blit_cmd_arbiter #(.NREQ(NREQ), .MIN_FREE(1), .HOLDOFF(2)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .enable_i               (enable),
    .blit_fifo_slots_free_i (slots),
    .bus                    (bus),
    .grant_id_o             (grant_id),
    .busy_o                 (busy),
    .issued_count_o         (issued_count)
  );

  blit_cmd_arbiter_chk #(.NREQ(NREQ)) chk (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (bus.req_valid),
    .req_ready      (bus.req_ready),
    .blit_cmd_valid (bus.blit_cmd_valid)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b0 || bus.req_ready !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got valid=%b ready=%b busy=%b expected 0 00 0",
               bus.blit_cmd_valid, bus.req_ready, busy);
    end
    vectors++;
    if (grant_id !== 3'd1 || issued_count !== 32'd0 || bus.blit_cmd !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got grant=%0d count=%0d cmd=%h expected 1 0 0",
               grant_id, issued_count, bus.blit_cmd);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    bus.req_cmd   = {CMD1, CMD_A};
    bus.req_valid = 2'b01;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b1 || bus.req_ready !== 2'b01 || bus.blit_cmd !== CMD_A) begin
      miscompares++;
      $display("FAIL single_issue: got valid=%b ready=%b cmd=%h expected 1 01 %h",
               bus.blit_cmd_valid, bus.req_ready, bus.blit_cmd, CMD_A);
    end
    vectors++;
    if (issued_count !== 32'd1 || busy !== 1'b1 || grant_id !== 3'd0) begin
      miscompares++;
      $display("FAIL single_count: got count=%0d busy=%b grant=%0d expected 1 1 0",
               issued_count, busy, grant_id);
    end
    bus.req_valid = 2'b00;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b0 || bus.req_ready !== 2'b00 || busy !== 1'b1
        || bus.blit_cmd !== CMD_A) begin
      miscompares++;
      $display("FAIL single_hold2: got valid=%b ready=%b busy=%b cmd=%h expected 0 00 1 %h",
               bus.blit_cmd_valid, bus.req_ready, busy, bus.blit_cmd, CMD_A);
    end
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic       exp_valid;
    logic [2:0] exp_grant;
    logic [1:0] exp_ready;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n       = 1'b1;
    bus.req_cmd   = {CMD1, CMD0};
    bus.req_valid = 2'b11;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      exp_valid = (k % 3 == 1);
      exp_grant = 3'(((k - 1) / 3) % 2);
      exp_ready = exp_valid ? (2'b01 << exp_grant) : 2'b00;
      vectors++;
      if (bus.blit_cmd_valid !== exp_valid || bus.req_ready !== exp_ready
          || grant_id !== exp_grant) begin
        miscompares++;
        $display("FAIL rr_cycle%0d: got valid=%b ready=%b grant=%0d expected %b %b %0d",
                 k, bus.blit_cmd_valid, bus.req_ready, grant_id, exp_valid, exp_ready, exp_grant);
      end
      if (exp_valid) begin
        vectors++;
        if (bus.blit_cmd !== (exp_grant == 3'd0 ? CMD0 : CMD1)) begin
          miscompares++;
          $display("FAIL rr_cmd%0d: got %h expected cmd of req %0d", k, bus.blit_cmd, exp_grant);
        end
      end
    end
    vectors++;
    if (issued_count !== 32'd4) begin
      miscompares++;
      $display("FAIL rr_count: got %0d expected 4", issued_count);
    end
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_no_slots();
    slots         = 8'd0;
    bus.req_valid = 2'b10;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      vectors++;
      if (bus.blit_cmd_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL noslot_cycle%0d: got valid=%b ready=%b expected 0 00",
                 k, bus.blit_cmd_valid, bus.req_ready);
      end
    end
    slots = 8'd3;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b1 || bus.req_ready !== 2'b10 || grant_id !== 3'd1
        || bus.blit_cmd !== CMD1) begin
      miscompares++;
      $display("FAIL noslot_release: got valid=%b ready=%b grant=%0d cmd=%h expected 1 10 1 %h",
               bus.blit_cmd_valid, bus.req_ready, grant_id, bus.blit_cmd, CMD1);
    end
    bus.req_valid = 2'b00;
    slots         = 8'd16;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_enable();
    bus.req_valid = 2'b01;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b1 || bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL en_first: got valid=%b ready=%b expected 1 01",
               bus.blit_cmd_valid, bus.req_ready);
    end
    enable = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || bus.blit_cmd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en_hold: got busy=%b valid=%b expected 1 0", busy, bus.blit_cmd_valid);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      vectors++;
      if (busy !== 1'b0 || bus.blit_cmd_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL en_off%0d: got busy=%b valid=%b expected 0 0",
                 k, busy, bus.blit_cmd_valid);
      end
    end
    enable = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b1 || bus.req_ready !== 2'b01 || issued_count !== 32'd7) begin
      miscompares++;
      $display("FAIL en_resume: got valid=%b ready=%b count=%0d expected 1 01 7",
               bus.blit_cmd_valid, bus.req_ready, issued_count);
    end
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_hold();
    bus.req_valid = 2'b11;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b1 || bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_pre: got valid=%b ready=%b expected 1 10",
               bus.blit_cmd_valid, bus.req_ready);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.blit_cmd_valid !== 1'b0 || bus.req_ready !== 2'b00 || busy !== 1'b0
        || grant_id !== 3'd1 || issued_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%b ready=%b busy=%b grant=%0d count=%0d expected 0 00 0 1 0",
               bus.blit_cmd_valid, bus.req_ready, busy, grant_id, issued_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.blit_cmd_valid !== 1'b1 || bus.req_ready !== 2'b01 || grant_id !== 3'd0
        || issued_count !== 32'd1) begin
      miscompares++;
      $display("FAIL rst_rearb: got valid=%b ready=%b grant=%0d count=%0d expected 1 01 0 1",
               bus.blit_cmd_valid, bus.req_ready, grant_id, issued_count);
    end
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_wrap();
    force dut.issued_count_q = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    release dut.issued_count_q;
    @(negedge clock);
    vectors++;
    if (issued_count !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: got %h expected ffffffff", issued_count);
    end
    bus.req_valid = 2'b01;
    @(negedge clock);
    vectors++;
    if (issued_count !== 32'd0 || bus.blit_cmd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_issue: got count=%h valid=%b expected 00000000 1",
               issued_count, bus.blit_cmd_valid);
    end
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b1;
    slots         = 8'd16;
    bus.req_valid = 2'b00;
    bus.req_cmd   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_no_slots();
    test_enable();
    test_reset_mid_hold();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
